// File: rtl/move_entry.sv
// Player-input front end: synchronises and debounces the button and move switches,
// validates the move and runs the enter/ready handshake toward the game core.
module move_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_raw,
    input  logic [2:0] sw_raw,
    input  logic       ready,
    input  logic       gameover,
    output logic       enter,
    output logic [2:0] move,
    output logic       busy,
    output logic       reject,
    output logic [7:0] moves_made
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CHECK, DRIVE, RELEASE, REJECT} state_t;

    state_t        state;
    logic          btn_s1, btn_s2;
    logic [2:0]    sw_s1, sw_s2;
    logic          db_level;
    logic [DW-1:0] db_cnt;
    logic          press;
    logic [2:0]    move_q;
    logic [TW-1:0] to_cnt;
    logic          gameover_q;
    logic          go_rise;
    logic          accept;
    logic          move_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw_s2  <= sw_s1;
        end
    end

    // Count consecutive samples that disagree with the debounced level; flip after enough.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (btn_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= btn_s2;
                db_cnt   <= '0;
                press    <= btn_s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign go_rise    = gameover & ~gameover_q;
    assign accept     = (state == DRIVE) && !ready;
    assign move_valid = (move_q != 3'd0) && (move_q < 3'd6);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            enter      <= 1'b0;
            move       <= '0;
            reject     <= 1'b0;
            move_q     <= '0;
            to_cnt     <= '0;
            gameover_q <= 1'b0;
            moves_made <= '0;
        end else begin
            gameover_q <= gameover;
            reject     <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        move_q <= sw_s2;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (!move_valid) begin
                        reject <= 1'b1;
                        state  <= REJECT;
                    end else if (ready) begin
                        enter  <= 1'b1;
                        move   <= move_q;
                        to_cnt <= '0;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!ready) begin
                        enter <= 1'b0;
                        state <= RELEASE;
                    end else if (to_cnt == TO_LAST) begin
                        enter  <= 1'b0;
                        reject <= 1'b1;
                        state  <= REJECT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                REJECT: state <= RELEASE;
                RELEASE: begin
                    if (!db_level && ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A gameover rise wins over a same-cycle accept.
            if (go_rise)
                moves_made <= '0;
            else if (accept && moves_made != 8'hFF)
                moves_made <= moves_made + 8'd1;
        end
    end

endmodule

// File: tb/tb_move_entry.sv
// Scoreboard bench for move_entry: expected enter/reject events are queued per press
// and matched against what the DUT produces.
module tb_move_entry;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_raw;
    logic [2:0] sw_raw;
    logic       ready;
    logic       gameover;
    logic       enter;
    logic [2:0] move;
    logic       busy;
    logic       reject;
    logic [7:0] moves_made;

    move_entry #(.DEBOUNCE_CYCLES(16), .ACK_TIMEOUT(64)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .ready      (ready),
        .gameover   (gameover),
        .enter      (enter),
        .move       (move),
        .busy       (busy),
        .reject     (reject),
        .moves_made (moves_made)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         is_rej;
        logic [2:0] mv;
        int         dur;
    } evt_t;

    evt_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_moves = 0;
    bit   refuse = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Core model: accepts by dropping ready two cycles into enter, unless refusing.
    initial begin
        int hold;
        hold = 0;
        ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (enter && ready && !refuse) begin
                hold++;
                if (hold == 2) begin
                    ready = 1'b0;
                    hold = 0;
                    repeat (3) @(posedge clock);
                    #1 ready = 1'b1;
                end
            end else begin
                hold = 0;
            end
        end
    end

    // Output monitor: pops expected events as the DUT produces them.
    initial begin
        logic       enter_d;
        logic [2:0] mv_seen;
        int         dur;
        evt_t       e;
        enter_d = 1'b0;
        mv_seen = '0;
        dur = 0;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (enter && !enter_d) begin
                    mv_seen = move;
                    dur = 1;
                end else if (enter) begin
                    dur++;
                    check("move_stable", int'(move), int'(mv_seen));
                end
                if (!enter && enter_d) begin
                    if (sb.size() == 0) begin
                        check("unexpected_enter", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("evt_is_enter", int'(e.is_rej), 0);
                        check("enter_move", int'(mv_seen), int'(e.mv));
                        check("enter_cycles", dur, e.dur);
                    end
                end
                if (reject) begin
                    if (sb.size() == 0) begin
                        check("unexpected_reject", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("evt_is_reject", int'(e.is_rej), 1);
                    end
                end
            end
            enter_d = enter;
        end
    end

    task automatic do_press(input logic [2:0] sw, input int hold, input bit bounce);
        evt_t e;
        int   waited;
        if (sw >= 3'd1 && sw <= 3'd5) begin
            e.is_rej = 1'b0;
            e.mv = sw;
            e.dur = refuse ? 64 : 2;
            sb.push_back(e);
            if (refuse) begin
                e.is_rej = 1'b1;
                e.dur = 0;
                sb.push_back(e);
            end else if (exp_moves < 255) begin
                exp_moves++;
            end
        end else begin
            e.is_rej = 1'b1;
            e.mv = sw;
            e.dur = 0;
            sb.push_back(e);
        end
        @(negedge clock);
        sw_raw = sw;
        repeat (4) @(negedge clock);
        if (bounce) begin
            for (int i = 0; i < 5; i++) begin
                btn_raw = 1'b1;
                repeat (3) @(negedge clock);
                btn_raw = 1'b0;
                repeat (3) @(negedge clock);
            end
        end
        btn_raw = 1'b1;
        repeat (hold) @(negedge clock);
        btn_raw = 1'b0;
        waited = 0;
        while (busy && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        check("back_to_idle", int'(busy), 0);
        repeat (5) @(negedge clock);
        check("moves_made", int'(moves_made), exp_moves);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int waited;
        reset_n  = 1'b0;
        btn_raw  = 1'b0;
        sw_raw   = '0;
        gameover = 1'b0;
        #3;
        check("rst_enter", int'(enter), 0);
        check("rst_move", int'(move), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_moves", int'(moves_made), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clock);

        do_press(3'd3, 30, 1'b0);    // clean accepted move
        do_press(3'd2, 30, 1'b1);    // bouncy press -> one move
        do_press(3'd0, 30, 1'b0);    // invalid
        do_press(3'd6, 30, 1'b0);    // invalid
        refuse = 1'b1;
        do_press(3'd5, 30, 1'b0);    // refused by core
        refuse = 1'b0;
        do_press(3'd4, 1000, 1'b0);  // long hold -> single move
        do_press(3'd1, 30, 1'b0);
        do_press(3'd4, 30, 1'b0);
        do_press(3'd5, 30, 1'b0);
        do_press(3'd3, 30, 1'b0);
        check("moves_before_go", int'(moves_made), 7);

        @(negedge clock);
        gameover = 1'b1;
        @(posedge clock);
        #1;
        exp_moves = 0;
        check("gameover_clear", int'(moves_made), 0);
        @(negedge clock);
        gameover = 1'b0;
        do_press(3'd1, 30, 1'b0);

        // Asynchronous reset while enter is high.
        mon_en = 1'b0;
        refuse = 1'b1;
        sw_raw = 3'd4;
        repeat (4) @(negedge clock);
        btn_raw = 1'b1;
        waited = 0;
        while (!enter && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        check("enter_before_rst", int'(enter), 1);
        check("moves_before_rst", int'(moves_made), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_enter", int'(enter), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_moves", int'(moves_made), 0);
        btn_raw = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
